// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with enable and an auto-scan mode
// that walks the outputs up or down, holding each position for DWELL clocks.
module scan_decoder #(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                En,
    input  logic                Mode,
    input  logic                Dir,
    input  logic [N-1:0]        W,
    output logic [(1<<N)-1:0]   Y,
    output logic [N-1:0]        Idx,
    output logic                Wrap
);
    localparam int M  = 1 << N;
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DWELL - 1);
    localparam logic [M-1:0]  OFF_PAT = {M{ACTIVE_LOW}};
    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_DIRECT = 2'd1;
    localparam logic [1:0] S_START  = 2'd2;
    localparam logic [1:0] S_SCAN   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          prev_mode;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  idx_nxt;
    logic          adv, wrap_nxt;

    // prev_mode is the last mode seen while enabled; it decides resume vs reload after a pause
    always_comb begin
        state_nxt = !En ? S_OFF :
                    !Mode ? S_DIRECT :
                    (state == S_DIRECT || (state == S_OFF && !prev_mode)) ? S_START : S_SCAN;
        adv       = state_nxt == S_SCAN && cnt == LAST;
        idx_nxt   = (state_nxt == S_DIRECT || state_nxt == S_START) ? W :
                    adv ? (Dir ? Idx - 1'b1 : Idx + 1'b1) : Idx;
        cnt_nxt   = state_nxt == S_SCAN ? (adv ? '0 : cnt + 1'b1) :
                    state_nxt == S_OFF ? cnt : '0;
        wrap_nxt  = adv && (Dir ? Idx == '0 : Idx == '1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_OFF;
            prev_mode <= 1'b0;
            cnt       <= '0;
            Idx       <= '0;
            Wrap      <= 1'b0;
            Y         <= OFF_PAT;
        end else begin
            state     <= state_nxt;
            if (En) prev_mode <= Mode;
            cnt       <= cnt_nxt;
            Idx       <= idx_nxt;
            Wrap      <= wrap_nxt;
            Y         <= state_nxt == S_OFF ? OFF_PAT : OFF_PAT ^ (M'(1) << idx_nxt);
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: vector table, hand-written corner sequences and random stimulus against
// a behavioural model for scan_decoder (N=2, DWELL=3) plus an ACTIVE_LOW, DWELL=1 instance.
module tb_scan_decoder;
    localparam int DW = 3;
    localparam int SZ = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, en = 1'b1, mode = 1'b0, dir = 1'b0;
    logic [1:0] w = 2'd2;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       wrap_a;
    logic       rst_b = 1'b0, en_b = 1'b0, mode_b = 1'b0, dir_b = 1'b0;
    logic [1:0] w_b = 2'd0;
    logic [3:0] y_b;
    logic [1:0] idx_b;
    logic       wrap_b;

    int n_vec = 0, n_err = 0;
    int m_pos, m_held, m_on, m_wrap, m_scan;

    typedef struct { int en, mode, dir, w, y, idx, wrap; } vec_t;
    vec_t tbl[16];

    scan_decoder #(.N(2), .DWELL(DW), .ACTIVE_LOW(1'b0)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .Dir(dir), .W(w),
        .Y(y_a), .Idx(idx_a), .Wrap(wrap_a)
    );

    scan_decoder #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
        .Clk(clk), .Rst_n(rst_b), .En(en_b), .Mode(mode_b), .Dir(dir_b), .W(w_b),
        .Y(y_b), .Idx(idx_b), .Wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_held = 0; m_on = 0; m_wrap = 0; m_scan = 0;
    endtask

    // one clock of behaviour: a scan continues only if the last enabled mode was scan
    task automatic model_edge(input int e, input int md, input int d, input int wv);
        int np;
        m_wrap = 0;
        if (e == 0) m_on = 0;
        else if (md == 0 || m_scan == 0) begin
            m_pos = wv; m_held = 0; m_on = 1; m_scan = md;
        end else begin
            m_on = 1;
            m_held++;
            if (m_held == DW) begin
                m_held = 0;
                np = d != 0 ? m_pos - 1 : m_pos + 1;
                m_wrap = (np < 0 || np >= SZ) ? 1 : 0;
                m_pos = (np + SZ) % SZ;
            end
        end
    endtask

    task automatic step(input int e, input int md, input int d, input int wv);
        en = e != 0; mode = md != 0; dir = d != 0; w = 2'(wv);
        model_edge(e, md, d, wv);
        @(posedge clk);
        #2;
        cmp("model_y", 32'(y_a), 32'(m_on != 0 ? (1 << m_pos) : 0));
        cmp("model_idx", 32'(idx_a), 32'(m_pos));
        cmp("model_wrap", 32'(wrap_a), 32'(m_wrap));
    endtask

    task automatic chk(input string nm, input int ey, input int ei, input int ew);
        cmp({nm, "_y"}, 32'(y_a), 32'(ey));
        cmp({nm, "_idx"}, 32'(idx_a), 32'(ei));
        cmp({nm, "_wrap"}, 32'(wrap_a), 32'(ew));
    endtask

    initial begin
        int by[5], bi[5], bw[5];
        int e, md, d;
        tbl = '{
            '{1,0,0,0, 1,0,0}, '{1,0,0,1, 2,1,0}, '{1,0,0,2, 4,2,0}, '{1,0,0,3, 8,3,0},
            '{0,0,0,3, 0,3,0}, '{1,0,0,2, 4,2,0}, '{1,1,0,2, 4,2,0}, '{1,1,0,0, 4,2,0},
            '{1,1,0,0, 4,2,0}, '{1,1,0,0, 8,3,0}, '{1,1,0,0, 8,3,0}, '{1,1,0,0, 8,3,0},
            '{1,1,0,0, 1,0,1}, '{1,1,0,0, 1,0,0}, '{1,1,0,0, 1,0,0}, '{1,1,0,0, 2,1,0}
        };
        by = '{14, 13, 11, 7, 14};
        bi = '{0, 1, 2, 3, 0};
        bw = '{0, 0, 0, 0, 1};
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        chk("reset", 0, 0, 0);
        cmp("reset_b_y", 32'(y_b), 32'hf);
        @(negedge clk);
        rst_n = 1'b1;
        rst_b = 1'b1;
        #1;
        chk("release", 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].mode, tbl[i].dir, tbl[i].w);
            chk($sformatf("tbl%0d", i), tbl[i].y, tbl[i].idx, tbl[i].wrap);
        end

        step(1, 0, 0, 1); chk("dn_direct", 2, 1, 0);
        step(1, 1, 1, 1); chk("dn_start", 2, 1, 0);
        step(1, 1, 1, 0); chk("dn_h1", 2, 1, 0);
        step(1, 1, 1, 0); chk("dn_h2", 2, 1, 0);
        step(1, 1, 1, 0); chk("dn_p0a", 1, 0, 0);
        step(1, 1, 1, 0); chk("dn_p0b", 1, 0, 0);
        step(1, 1, 1, 0); chk("dn_p0c", 1, 0, 0);
        step(1, 1, 1, 0); chk("dn_wrap", 8, 3, 1);
        step(1, 1, 1, 0); chk("flip_c2", 8, 3, 0);
        step(1, 1, 0, 0); chk("flip_c3", 8, 3, 0);
        step(1, 1, 0, 0); chk("flip_upwrap", 1, 0, 1);

        step(1, 0, 0, 3); chk("pz_direct", 8, 3, 0);
        step(1, 1, 0, 3); chk("pz_c1", 8, 3, 0);
        step(1, 1, 0, 3); chk("pz_c2", 8, 3, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0); chk($sformatf("pz_off%0d", i), 0, 3, 0);
        end
        step(1, 1, 0, 0); chk("pz_resume", 8, 3, 0);
        step(1, 1, 0, 0); chk("pz_wrap", 1, 0, 1);
        step(1, 1, 0, 0); chk("pz_after", 1, 0, 0);

        e = 1; md = 0; d = 0;
        for (int i = 0; i < 400; i++) begin
            e = $urandom_range(0, 9) != 0 ? 1 : 0;
            if ($urandom_range(0, 7) == 0) md = 1 - md;
            if ($urandom_range(0, 3) == 0) d = 1 - d;
            step(e, md, d, int'($urandom_range(0, 3)));
        end

        step(1, 0, 0, 3);
        step(1, 1, 0, 3);
        step(1, 1, 0, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 0, 0, 0);
        model_reset();

        @(negedge clk);
        en_b = 1'b1; mode_b = 1'b1; dir_b = 1'b0; w_b = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            cmp($sformatf("b_y%0d", i), 32'(y_b), 32'(by[i]));
            cmp($sformatf("b_idx%0d", i), 32'(idx_b), 32'(bi[i]));
            cmp($sformatf("b_wrap%0d", i), 32'(wrap_b), 32'(bw[i]));
        end
        #3;
        rst_b = 1'b0;
        #1;
        cmp("b_async_y", 32'(y_b), 32'hf);
        cmp("b_async_idx", 32'(idx_b), 32'd0);
        cmp("b_async_wrap", 32'(wrap_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable, the next generation of the lab 2:4 decoder.
- Adds an auto-scan mode: an internal index walks the outputs up or down, holding each position for DWELL clocks.
- Intended to drive LED and seven-segment digit-select lines in later labs.
- Outputs are registered, so the block is glitch-free at the pins.

Parameters:
- N, 2, select width; output width is 2^N (N >= 1).
- DWELL, 4, clocks each position is held in scan mode (DWELL >= 1).
- ACTIVE_LOW, 0, output polarity: 1 inverts every bit of Y, including the all-off pattern.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- En  input  1  enable; 0 forces outputs off and freezes scan state.
- Mode  input  1  0 = direct decode of W; 1 = auto-scan.
- Dir  input  1  scan direction: 0 = up (index +1), 1 = down (index -1); sampled each advance.
- W  input  N  select in direct mode; start index on scan entry.
- Y  output  2^N  registered one-hot output (polarity per ACTIVE_LOW).
- Idx  output  N  registered index currently decoded.
- Wrap  output  1  one-clock pulse on a scan wrap-around.

Behaviour:
- Port types: all inputs are wire, all outputs are reg, single clock domain. Reset is asynchronous and active-low, named Rst_n; the clock is Clk.
- Off pattern: 0 when ACTIVE_LOW=0; all ones when ACTIVE_LOW=1.
- Reset (Rst_n=0, asynchronous):
  - Y = off pattern, Idx = 0, Wrap = 0.
  - Dwell counter = 0, FSM = OFF, registered previous Mode = 0.
  - Release is synchronous to the next rising Clk.
- Dwell counter width: $clog2(DWELL), minimum 1 bit.
- FSM states: OFF, DIRECT, SCAN_START, SCAN. Evaluated every rising edge:
  - Any state, En=0 -> OFF.
    - Y = off pattern, Wrap = 0.
    - Idx and dwell counter hold their values.
    - FSM remembers the last active mode.
  - En=1, Mode=0 -> DIRECT.
    - Idx <= W, Y <= onehot(W), dwell counter <= 0, Wrap = 0.
    - Latency: one clock from W to Y.
  - En=1, Mode=1, previous state DIRECT -> SCAN_START.
    - Entry from DIRECT on the Mode 0->1 transition.
    - Idx <= W, Y <= onehot(W), dwell counter <= 0, Wrap = 0.
  - En=1, Mode=1, previous state OFF after a scan -> SCAN.
    - Resumes with the held Idx and dwell counter; no reload.
  - En=1, Mode=1, previous state OFF with no prior scan since reset -> SCAN_START from W.
  - SCAN_START -> SCAN on the next clock when En=1 and Mode=1.
- SCAN advance:
  - Each clock the dwell counter increments.
  - When the counter equals DWELL-1: counter <= 0 and Idx advances by +1 or -1 mod 2^N, per Dir.
  - Y <= onehot(new Idx) on the same edge.
  - DWELL=1 means an advance every clock.
- Wrap:
  - Asserted for exactly the one clock in which Y shows the post-wrap position.
  - Up wrap: Idx 2^N-1 -> 0. Down wrap: Idx 0 -> 2^N-1.
  - Never asserted in DIRECT, OFF or SCAN_START.
- Dir changed mid-dwell takes effect at the next advance; the dwell count is not reset.
- Mode 1->0 with En=1: the next edge decodes W directly and the scan position is discarded.
- Y always equals onehot(Idx) (with polarity applied) except in OFF.
- Y is never more than one-hot, and never X after reset.
- Idx arithmetic is N-bit modular. No combinational path from any input to Y, Idx or Wrap.
- Reset asserted mid-scan: outputs go to reset values immediately, without waiting for a clock edge.

Test Plan (N=2, DWELL=3, ACTIVE_LOW=0 unless stated):
- Reset: hold Rst_n=0 while toggling Clk with En=1 -> Y=0000, Idx=00, Wrap=0. Deassert Rst_n mid-cycle -> no change until the next rising edge.
- Direct mode: En=1, Mode=0, W = 00,01,10,11 on consecutive clocks -> Y = 0001,0010,0100,1000, each one clock later. En=0 -> Y=0000 on the next edge.
- Scan up from W=10: Mode 0->1 -> Y=0100 held 3 clocks, then 1000 x3, then 0001 with Wrap=1 for one clock, then 0010.
- Scan down with a mid-dwell Dir change:
  - Dir=1 from Idx=01 -> 0010 x3, then 0001 x3, then 1000 with Wrap=1.
  - Flip Dir to 0 on the 2nd clock of a dwell -> that dwell still lasts 3 clocks, then Idx goes up.
- Pause/resume: En=0 for 5 clocks on the 2nd clock of Idx=11 -> Y=0000 and Wrap=0 throughout. En=1 -> Idx=11 resumes, stays for the remaining dwell, then Idx=00 with Wrap.
- ACTIVE_LOW=1, DWELL=1:
  - Reset -> Y=1111.
  - Scan up -> Y = 1110,1101,1011,0111,1110 on successive clocks, Wrap on the 5th.
  - Assert Rst_n=0 between edges -> Y=1111 immediately.
